// File: rtl/dmem_pkg.sv
// Shared funct3 codes and access-decode helpers for the byte-enabled data memory LSU.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Lane write enables for a store of the size in funct3[1:0] at byte offset off.
  function automatic logic [3:0] lane_be(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
    return ((funct3[1:0] == 2'b01) && off[0]) || ((funct3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic illegal_f3(input logic we, input logic [2:0] funct3);
    logic bad;
    bad = 1'b1;
    case ({we, funct3})
      4'b0_000, 4'b0_001, 4'b0_010, 4'b0_100, 4'b0_101: bad = 1'b0;
      4'b1_000, 4'b1_001, 4'b1_010:                     bad = 1'b0;
      default:                                          bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_ram_be.sv
// Single-port DEPTH_WORDS x 32 RAM with per-byte write enables and an enabled, registered read.
module dmem_ram_be #(
  parameter  int DEPTH_WORDS = 256,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             re,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents are deliberately not reset; rdata only moves when re is high.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_lsu.sv
// RV32 load/store unit over a byte-enabled data RAM with a one-cycle registered response.
// Optional macro DMEM_RANGE_CHK_EN: fault any address at or beyond DEPTH_WORDS*4.
module data_mem_lsu
  import dmem_pkg::*;
#(
  parameter  int ADDR_W      = 32,
  parameter  int DEPTH_WORDS = 256,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  // Handshake: a request transfers on a rising edge with req_valid && req_ready; a response
  // transfers with rsp_valid && rsp_ready and is replaced without a bubble by a same-edge accept.
  logic             accept;
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic             range_err;
  logic             err;
  logic [3:0]       ram_be;
  logic [31:0]      ram_wdata;
  logic             ram_re;
  logic [31:0]      ram_rdata;
  logic             ld_q;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic             addr_unused;

  assign req_ready   = !rsp_valid || rsp_ready;
  assign accept      = req_valid && req_ready;
  assign off         = req_addr[1:0];
  assign idx         = req_addr[IDX_W+1:2];
  assign addr_unused = ^req_addr;

`ifdef DMEM_RANGE_CHK_EN
  assign range_err = {1'b0, req_addr} >= (ADDR_W+1)'(DEPTH_WORDS * 4);
`else
  assign range_err = 1'b0;
`endif

  assign err    = illegal_f3(req_we, req_funct3) || misaligned(req_funct3, off) || range_err;
  assign ram_be = (accept && req_we && !err) ? lane_be(req_funct3, off) : 4'b0000;
  assign ram_re = accept && !req_we && !err;

  always_comb begin
    ram_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00:   ram_wdata = {4{req_wdata[7:0]}};
      2'b01:   ram_wdata = {2{req_wdata[15:0]}};
      default: ram_wdata = req_wdata;
    endcase
  end

  dmem_ram_be #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .be    (ram_be),
    .idx   (idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      ld_q      <= 1'b0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= err;
      ld_q      <= ram_re;
      off_q     <= off;
      f3_q      <= req_funct3;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Lane select and extension; stores and faulted accesses read back as zero.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b         = ram_rdata[{off_q, 3'b000} +: 8];
    h         = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    rsp_rdata = 32'h0;
    if (ld_q) begin
      case (f3_q)
        F3_B:    rsp_rdata = {{24{b[7]}}, b};
        F3_H:    rsp_rdata = {{16{h[15]}}, h};
        F3_W:    rsp_rdata = ram_rdata;
        F3_BU:   rsp_rdata = {24'h0, b};
        F3_HU:   rsp_rdata = {16'h0, h};
        default: rsp_rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed loads/stores, faults, backpressure, reset, random traffic.
module tb_data_mem_lsu;
  import dmem_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int          n_checks = 0;
  int          n_errors = 0;
  int          rsp_count = 0;
  logic [32:0] exp_q[$];
  logic [32:0] sb_exp;

  always #5 clk = ~clk;

  data_mem_lsu #(.ADDR_W(32), .DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  // Scoreboard: every response consumed is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      rsp_count++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got err=%0b rdata=%08h, no response expected", rsp_err, rsp_rdata);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({rsp_err, rsp_rdata} !== sb_exp) begin
          n_errors++;
          $display("FAIL sb_rsp: got err=%0b rdata=%08h, want err=%0b rdata=%08h",
                   rsp_err, rsp_rdata, sb_exp[32], sb_exp[31:0]);
        end
      end
    end
  end

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata);
    bit done;
    done       = 1'b0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back({exp_err, exp_rdata});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_timeout: addr=%08h never accepted", addr);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d responses still pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_state: got valid=%0b err=%0b rdata=%08h ready=%0b, want 0 0 00000000 1",
               rsp_valid, rsp_err, rsp_rdata, req_ready);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load();
    req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    n_checks++;
    if ({rsp_valid, rsp_err} !== 2'b10) begin
      n_errors++;
      $display("FAIL sw_latency: got valid=%0b err=%0b one cycle after accept, want 1 0", rsp_valid, rsp_err);
    end
    req(1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    n_checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      n_errors++;
      $display("FAIL lw_latency: got valid=%0b rdata=%08h, want 1 deadbeef", rsp_valid, rsp_rdata);
    end
    drain();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rsp_idle: got valid=%0b after drain, want 0", rsp_valid);
    end
  endtask

  task automatic test_byte();
    req(1'b1, F3_B,  32'h11, 32'h12345680, 1'b0, 32'h0);
    req(1'b0, F3_B,  32'h11, 32'h0, 1'b0, 32'hFFFFFF80);
    req(1'b0, F3_BU, 32'h11, 32'h0, 1'b0, 32'h00000080);
    req(1'b0, F3_W,  32'h10, 32'h0, 1'b0, 32'hDEAD80EF);
    drain();
  endtask

  task automatic test_half();
    req(1'b1, F3_W,  32'h20, 32'h00000000, 1'b0, 32'h0);
    req(1'b1, F3_H,  32'h22, 32'hABCD8001, 1'b0, 32'h0);
    req(1'b0, F3_H,  32'h22, 32'h0, 1'b0, 32'hFFFF8001);
    req(1'b0, F3_HU, 32'h22, 32'h0, 1'b0, 32'h00008001);
    req(1'b0, F3_W,  32'h20, 32'h0, 1'b0, 32'h80010000);
    req(1'b0, F3_H,  32'h21, 32'h0, 1'b1, 32'h0);
    n_checks++;
    if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0}) begin
      n_errors++;
      $display("FAIL lh_misaligned: got err=%0b rdata=%08h, want 1 00000000", rsp_err, rsp_rdata);
    end
    drain();
  endtask

  task automatic test_faults();
    req(1'b1, F3_W,   32'h13, 32'h55555555, 1'b1, 32'h0);
    req(1'b0, F3_W,   32'h10, 32'h0, 1'b0, 32'hDEAD80EF);
    req(1'b1, F3_H,   32'h11, 32'h00007777, 1'b1, 32'h0);
    req(1'b1, 3'b100, 32'h10, 32'h66666666, 1'b1, 32'h0);
    req(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0);
    req(1'b0, 3'b110, 32'h10, 32'h0, 1'b1, 32'h0);
    req(1'b0, F3_W,   32'h10, 32'h0, 1'b0, 32'hDEAD80EF);
    drain();
  endtask

  task automatic test_back_to_back();
    int start_count;
    for (int i = 0; i < 4; i++) req(1'b1, F3_W, 32'h80 + 32'(4 * i), 32'h11110000 + 32'(i), 1'b0, 32'h0);
    drain();
    start_count = rsp_count;
    req(1'b0, F3_W, 32'h80, 32'h0, 1'b0, 32'h11110000);
    rsp_ready  = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 32'h84;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({req_ready, rsp_valid, rsp_rdata} !== {1'b0, 1'b1, 32'h11110000}) begin
        n_errors++;
        $display("FAIL backpressure_hold: cycle %0d got ready=%0b valid=%0b rdata=%08h, want 0 1 11110000",
                 i, req_ready, rsp_valid, rsp_rdata);
      end
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    for (int i = 1; i < 4; i++) req(1'b0, F3_W, 32'h80 + 32'(4 * i), 32'h0, 1'b0, 32'h11110000 + 32'(i));
    drain();
    n_checks++;
    if (rsp_count - start_count != 4) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d responses, want 4", rsp_count - start_count);
    end
  endtask

  task automatic test_wrap();
    req(1'b1, F3_W, 32'h0, 32'h0BADF00D, 1'b0, 32'h0);
`ifdef DMEM_RANGE_CHK_EN
    req(1'b1, F3_W, 32'h400, 32'h12345678, 1'b1, 32'h0);
    req(1'b0, F3_W, 32'h400, 32'h0, 1'b1, 32'h0);
    req(1'b0, F3_W, 32'h0, 32'h0, 1'b0, 32'h0BADF00D);
`else
    req(1'b1, F3_W, 32'h400, 32'h12345678, 1'b0, 32'h0);
    req(1'b0, F3_W, 32'h0, 32'h0, 1'b0, 32'h12345678);
    req(1'b0, F3_BU, 32'hFFFF_0402, 32'h0, 1'b0, 32'h00000034);
`endif
    req(1'b0, F3_W, 32'h3FC, 32'h0, 1'b0, 32'hCAFEF00D);
    drain();
  endtask

  task automatic test_reset_mid();
    req(1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'hDEAD80EF);
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      n_errors++;
      $display("FAIL reset_mid: got valid=%0b err=%0b rdata=%08h, want 0 0 00000000", rsp_valid, rsp_err, rsp_rdata);
    end
    exp_q.delete();
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req(1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'hDEAD80EF);
    drain();
  endtask

  task automatic test_random();
    logic [7:0]  mdl [32];
    logic [31:0] a, w, e;
    int          op;
    for (int i = 0; i < 8; i++) begin
      w = $urandom();
      {mdl[4*i+3], mdl[4*i+2], mdl[4*i+1], mdl[4*i]} = w;
      req(1'b1, F3_W, 32'h40 + 32'(4 * i), w, 1'b0, 32'h0);
    end
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      w  = $urandom();
      a  = 32'($urandom_range(0, 31));
      case (op)
        0: begin
          a = {a[31:2], 2'b00};
          {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]} = w;
          req(1'b1, F3_W, 32'h40 + a, w, 1'b0, 32'h0);
        end
        1: begin
          mdl[a] = w[7:0];
          req(1'b1, F3_B, 32'h40 + a, w, 1'b0, 32'h0);
        end
        2: begin
          a = {a[31:2], 2'b00};
          e = {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
          req(1'b0, F3_W, 32'h40 + a, 32'h0, 1'b0, e);
        end
        default: begin
          e = {{24{mdl[a][7]}}, mdl[a]};
          req(1'b0, F3_B, 32'h40 + a, 32'h0, 1'b0, e);
        end
      endcase
    end
    drain();
  endtask

  initial begin
    test_reset();
    req(1'b1, F3_W, 32'h3FC, 32'hCAFEF00D, 1'b0, 32'h0);
    drain();
    test_store_load();
    test_byte();
    test_half();
    test_faults();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Parametrised successor to the single-cycle word data memory.
- Word-organised, byte-enabled data RAM with a valid/ready request channel and a registered response channel.
- Executes RV32 load/store sizes: LB/LH/LW/LBU/LHU and SB/SH/SW.
- Sits between the core's MEM stage and the on-chip data store. Flags misaligned and illegal accesses instead of silently corrupting memory.

Parameters:
- ADDR_W, 32, width of the byte address input.
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of two, at least 2.
- IDX_W, $clog2(DEPTH_WORDS), word-index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising clk edge.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 size/sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  access faulted; nothing written.

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_rdata=0, rsp_err=0. RAM contents are not reset.
- req_ready = !rsp_valid || rsp_ready. This is combinational and gives one request per cycle throughput.
- Word index = req_addr[IDX_W+1:2]. Byte offset = req_addr[1:0].
- Legal codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal and set err.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. Sets err.
- Store at accept edge:
  - If no err, byte-enable write at that edge. SB lane = offset; SH lanes = offset, offset+1; SW all lanes.
  - wdata bytes are replicated into the addressed lanes.
- Load at accept edge: RAM word and offset/funct3 are registered. rsp_rdata selects lane(s), then sign- or zero-extends.
- Response latency is exactly 1 cycle after accept for both loads and stores. rsp_valid rises on the next edge.
- Backpressure: while rsp_valid && !rsp_ready, rsp_rdata and rsp_err hold stable and req_ready=0. No RAM read register update occurs.
- Same-edge response drain and new accept: the new response replaces the old one; there is no bubble.
- Load in the cycle after a store to the same word returns the new data. The write lands at the accept edge, before the next read.
- Without range check, word index wraps modulo DEPTH_WORDS. Upper address bits are ignored.
- Reset mid-response drops the response. A store accepted on the same edge as the reset release is not guaranteed.

Optional Feature:
- Macro: DMEM_RANGE_CHK_EN.
- Defined: any req_addr >= DEPTH_WORDS*4 sets rsp_err=1, suppresses the write, and gives rsp_rdata=0.
- Undefined: no range check; the address wraps as above.

Decomposition:
- Package dmem_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Lane byte-enable helper function.
  - Misalign predicate function.
- Sub-module dmem_ram_be: DEPTH_WORDS x 32 RAM with 4-bit byte write enable and registered read port enable.
- data_mem_lsu keeps the handshake, error decode, and load extraction logic.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_rdata=0xDEADBEEF, err=0, each response 1 cycle after accept.
- SB 0x80 @0x11, then LB @0x11 → 0xFFFFFF80; LBU @0x11 → 0x00000080; LW @0x10 → 0xDEAD80EF.
- SH 0x8001 @0x22, then LH @0x22 → 0xFFFF8001; LHU → 0x00008001; LH @0x21 → err=1, rdata=0.
- SW @0x13 (misaligned) then LW @0x10 → store response err=1; following load returns the unchanged 0xDEAD80EF.
- Back-to-back LW stream with rsp_ready low for 3 cycles → req_ready=0 and rsp_rdata held for those cycles; no response is lost or duplicated after release.
- With DMEM_RANGE_CHK_EN, DEPTH_WORDS=256: SW @0x400 → err=1. Without the macro, SW @0x400 then LW @0x000 → written value is visible.
